// File: rtl/uart_boot_loader.sv
// UART boot loader: parses sync/length/data frames from the RX byte stream into instruction-memory writes.
// Optional build macro BOOT_CHECKSUM_EN appends a trailing XOR checksum byte and a CHECK state.
module uart_boot_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned TIMEOUT   = 1000000,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   input  logic              boot_req_i,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_hold_o,
   output logic              boot_done_o,
   output logic              boot_err_o
);

   localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);
   localparam int unsigned IDX_W = ADDR_W + 1;
   localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

`ifdef BOOT_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_e;
`else
   typedef enum logic [2:0] {
      S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERROR
   } state_e;
`endif

   state_e             state_q;
   logic [15:0]        len_q;
   logic [IDX_W-1:0]   word_idx_q;
   logic [1:0]         byte_idx_q;
   logic [23:0]        buf_q;
   logic [GAP_W-1:0]   gap_q;
   logic               imem_we_q;
   logic [ADDR_W-1:0]  imem_addr_q;
   logic [31:0]        imem_wdata_q;
   logic               cpu_hold_q;
   logic               boot_done_q;
   logic               boot_err_q;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]         csum_q;
`endif

   logic [15:0] len_d;
   logic        last_word;
   logic        gap_expired;
   logic        in_frame;

   assign len_d       = {rx_data_i, len_q[7:0]};
   assign last_word   = (32'(word_idx_q) == (32'(len_q) - 32'd1));
   assign gap_expired = (gap_q == GAP_W'(TIMEOUT - 1));
`ifdef BOOT_CHECKSUM_EN
   assign in_frame    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
`else
   assign in_frame    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA);
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_WAIT_SYNC;
         len_q        <= '0;
         word_idx_q   <= '0;
         byte_idx_q   <= '0;
         buf_q        <= '0;
         gap_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         cpu_hold_q   <= 1'b1;
         boot_done_q  <= 1'b0;
         boot_err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         imem_we_q <= 1'b0;

         // Inter-byte gap watchdog; an accepted byte in the expiry cycle wins
         if (in_frame && !rx_valid_i) begin
            if (gap_expired) begin
               state_q    <= S_ERROR;
               boot_err_q <= 1'b1;
               cpu_hold_q <= 1'b1;
               gap_q      <= '0;
            end else begin
               gap_q <= gap_q + GAP_W'(1);
            end
         end else begin
            gap_q <= '0;
         end

         case (state_q)
            S_WAIT_SYNC: begin
               if (rx_valid_i && (rx_data_i == SYNC_BYTE)) begin
                  state_q <= S_LEN_LO;
`ifdef BOOT_CHECKSUM_EN
                  csum_q  <= '0;
`endif
               end
            end
            S_LEN_LO: begin
               if (rx_valid_i) begin
                  len_q   <= {8'h00, rx_data_i};
                  state_q <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (rx_valid_i) begin
                  len_q      <= len_d;
                  word_idx_q <= '0;
                  byte_idx_q <= '0;
                  if (len_d == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                     state_q     <= S_CHECK;
`else
                     state_q     <= S_DONE;
                     boot_done_q <= 1'b1;
                     cpu_hold_q  <= 1'b0;
`endif
                  end else if (32'(len_d) > DEPTH) begin
                     state_q    <= S_ERROR;
                     boot_err_q <= 1'b1;
                     cpu_hold_q <= 1'b1;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (rx_valid_i) begin
`ifdef BOOT_CHECKSUM_EN
                  csum_q <= csum_q ^ rx_data_i;
`endif
                  byte_idx_q <= byte_idx_q + 2'd1;
                  // Bytes arrive LSB first, so shifting in from the top leaves them in place
                  if (byte_idx_q == 2'd3) begin
                     imem_we_q    <= 1'b1;
                     imem_wdata_q <= {rx_data_i, buf_q};
                     imem_addr_q  <= word_idx_q[ADDR_W-1:0];
                     word_idx_q   <= word_idx_q + IDX_W'(1);
                     if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                        state_q <= S_CHECK;
`else
                        state_q <= S_DONE;
`endif
                     end
                  end else begin
                     buf_q <= {rx_data_i, buf_q[23:8]};
                  end
               end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHECK: begin
               if (rx_valid_i) begin
                  if (rx_data_i == csum_q) begin
                     state_q     <= S_DONE;
                     boot_done_q <= 1'b1;
                     cpu_hold_q  <= 1'b0;
                  end else begin
                     state_q    <= S_ERROR;
                     boot_err_q <= 1'b1;
                     cpu_hold_q <= 1'b1;
                  end
               end
            end
`endif
            S_DONE, S_ERROR: begin
               if (boot_req_i) begin
                  state_q     <= S_WAIT_SYNC;
                  cpu_hold_q  <= 1'b1;
                  boot_done_q <= 1'b0;
                  boot_err_q  <= 1'b0;
                  word_idx_q  <= '0;
                  byte_idx_q  <= '0;
               end else if (state_q == S_DONE) begin
                  // Release lands one cycle after the final write strobe
                  cpu_hold_q  <= 1'b0;
                  boot_done_q <= 1'b1;
               end
            end
            default: state_q <= S_WAIT_SYNC;
         endcase
      end
   end

   assign imem_we_o    = imem_we_q;
   assign imem_addr_o  = imem_addr_q;
   assign imem_wdata_o = imem_wdata_q;
   assign cpu_hold_o   = cpu_hold_q;
   assign boot_done_o  = boot_done_q;
   assign boot_err_o   = boot_err_q;

endmodule
